// File: rtl/brush_stamp_writer_if.sv
// Request/status and frame-buffer index write signals of the brush stamp writer.
// The master side is the stamp writer; the slave side is the paint control and the frame buffer.
interface brush_stamp_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              iStart;
  logic [9:0]        iX;
  logic [9:0]        iY;
  logic [3:0]        iRadius;
  logic [7:0]        iColor;
  logic              oBusy;
  logic              oDone;
  logic              oWr_en;
  logic [ADDR_W-1:0] oWr_addr;
  logic [DATA_W-1:0] oWr_data;

  modport master (
    input  iStart, iX, iY, iRadius, iColor,
    output oBusy, oDone, oWr_en, oWr_addr, oWr_data
  );

  modport slave (
    output iStart, iX, iY, iRadius, iColor,
    input  oBusy, oDone, oWr_en, oWr_addr, oWr_data
  );
endinterface

// File: rtl/brush_stamp_writer.sv
// Paints a clipped square brush into the 640x480 colour-index frame buffer,
// one registered pixel write per clock in raster order.
module brush_stamp_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_R  = 15
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  brush_stamp_writer_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

  localparam logic [3:0]        MAX_R_V = 4'(MAX_R);
  localparam logic [10:0]       H_LIM   = 11'(H_RES);
  localparam logic [10:0]       V_LIM   = 11'(V_RES);
  localparam logic [10:0]       H_MAX   = 11'(H_RES - 1);
  localparam logic [10:0]       V_MAX   = 11'(V_RES - 1);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(H_RES);

  state_t            state;
  logic [9:0]        x_q, y_q;
  logic [3:0]        r_q;
  logic [7:0]        color_q;
  logic [9:0]        x0_q, x1_q, y1_q;
  logic [9:0]        col_q, row_q;
  logic [ADDR_W-1:0] base_q;

  logic              busy_q, done_q, wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              reject;
  logic [10:0]       xr_sum, yr_sum;
  logic [9:0]        x0_c, x1_c, y0_c, y1_c;
  logic [ADDR_W-1:0] base_c;

  // Clipped bounds from the latched cursor; guarded subtraction keeps x0/y0 from wrapping.
  always_comb begin
    reject = ({1'b0, x_q} >= H_LIM) || ({1'b0, y_q} >= V_LIM);
    x0_c   = (x_q >= {6'd0, r_q}) ? (x_q - {6'd0, r_q}) : '0;
    y0_c   = (y_q >= {6'd0, r_q}) ? (y_q - {6'd0, r_q}) : '0;
    xr_sum = {1'b0, x_q} + {7'd0, r_q};
    yr_sum = {1'b0, y_q} + {7'd0, r_q};
    x1_c   = (xr_sum > H_MAX) ? H_MAX[9:0] : xr_sum[9:0];
    y1_c   = (yr_sum > V_MAX) ? V_MAX[9:0] : yr_sum[9:0];
    // Row base as a sum of shifted copies of y0, one per set bit of the stride.
    base_c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (STRIDE[i]) base_c = base_c + (ADDR_W'(y0_c) << i);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      color_q <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            x_q     <= bus.iX;
            y_q     <= bus.iY;
            color_q <= bus.iColor;
            r_q     <= (bus.iRadius > MAX_R_V) ? MAX_R_V : bus.iRadius;
            busy_q  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (reject) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            x0_q    <= x0_c;
            x1_q    <= x1_c;
            y1_q    <= y1_c;
            col_q   <= x0_c;
            row_q   <= y0_c;
            base_q  <= base_c;
            wr_en_q <= 1'b1;
            addr_q  <= base_c + ADDR_W'(x0_c);
            data_q  <= DATA_W'(color_q);
            state   <= DRAW;
          end
        end
        DRAW: begin
          // The registered outputs already show the current pixel; this edge loads the next one.
          if (col_q == x1_q) begin
            if (row_q == y1_q) begin
              wr_en_q <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end else begin
              col_q  <= x0_q;
              row_q  <= row_q + 10'd1;
              base_q <= base_q + STRIDE;
              addr_q <= base_q + STRIDE + ADDR_W'(x0_q);
            end
          end else begin
            col_q  <= col_q + 10'd1;
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oBusy    = busy_q;
  assign bus.oDone    = done_q;
  assign bus.oWr_en   = wr_en_q;
  assign bus.oWr_addr = addr_q;
  assign bus.oWr_data = data_q;

endmodule

// File: doc/brush_stamp_writer.md
Name: brush_stamp_writer

Overview:
- Initiator for the frame-buffer index write port of vga_controller (data_index_in / data_memory_address_in / ctrl_index_write_enable).
- Paints a square brush of one colour index at a cursor position in the 640x480 index memory.
- Issues one pixel write per clock, clips the square to the screen, and signals busy/done to the paint control logic.

Parameters:
- H_RES, 640, visible pixels per line; also the row stride in the address.
- V_RES, 480, visible lines.
- ADDR_W, 32, width of the write address output.
- DATA_W, 32, width of the write data output (colour index zero-extended).
- MAX_R, 15, largest accepted brush radius; larger iRadius values saturate to MAX_R.

Ports:
- iCLK  in  1  processor/VGA clock domain clock
- iRST_n  in  1  asynchronous active-low reset
- iStart  in  1  single-cycle request to stamp; sampled only in IDLE
- iX  in  10  cursor column, 0..H_RES-1 valid
- iY  in  10  cursor row, 0..V_RES-1 valid
- iRadius  in  4  brush half-width r; square spans (x-r..x+r, y-r..y+r)
- iColor  in  8  colour index to write
- oBusy  out  1  high from the cycle after start acceptance through the oDone cycle
- oDone  out  1  one-cycle completion pulse
- oWr_en  out  1  frame-buffer write enable
- oWr_addr  out  ADDR_W  pixel address = row*H_RES + col
- oWr_data  out  DATA_W  {zeros, colour index}

Behaviour:
- Reset (async, iRST_n low): state IDLE. All outputs, including oBusy, oDone, oWr_en, oWr_addr and oWr_data, are 0 immediately. A stamp in progress is abandoned with no further writes.
- All outputs are registered.
- Start acceptance:
  - iStart high at a rising edge while in IDLE latches iX, iY, iColor and min(iRadius, MAX_R), and moves to SETUP.
  - iStart in any other state is ignored; there is no queueing.
- SETUP (1 cycle):
  - If iX >= H_RES or iY >= V_RES: reject and go to DONE. No writes are issued.
  - Otherwise compute clipped bounds: x0 = max(x-r,0), x1 = min(x+r,H_RES-1), y0 = max(y-r,0), y1 = min(y+r,V_RES-1). Use signed or guarded subtraction; no wrap below 0.
  - Compute row base = y0*H_RES using shift-add (640 = 512+128); no multiplier is inferred. Go to DRAW.
- DRAW:
  - Each cycle presents one write: oWr_en=1, oWr_addr = row_base+col, oWr_data = colour.
  - Scan order is raster: col runs x0..x1. At col==x1 it wraps to x0 and row_base += H_RES.
  - After the write at (x1,y1) go to DONE.
  - Exactly (x1-x0+1)*(y1-y0+1) writes are issued, with no gaps and no duplicates.
- DONE (1 cycle): oDone=1, oWr_en=0, then return to IDLE. oBusy drops in the cycle after DONE.
- Latency:
  - Start sampled at edge T; the first write is valid in the cycle after edge T+1.
  - oDone occurs the cycle after the last write.
  - A reject pulses oDone in the cycle after edge T+1.
- oBusy is high in SETUP, DRAW and DONE.
- oWr_addr and oWr_data hold their last values when oWr_en=0 (don't-care for the consumer). They are 0 after reset.
- Inputs may change freely after acceptance; only latched copies are used.
- Back-to-back: iStart asserted in the cycle oBusy falls (IDLE) is accepted.

Test Plan:
- Centre stamp: x=100, y=50, r=1, color=0x2A.
  - Required: 9 consecutive writes, addresses 31459, 31460, 31461, 32099, 32100, 32101, 32739, 32740, 32741.
  - Data 0x0000002A on every write.
  - oDone one cycle after the last write.
- Top-left clip: x=0, y=0, r=2 → 9 writes to 0, 1, 2, 640, 641, 642, 1280, 1281, 1282. No address wraps negative.
- Bottom-right clip: x=639, y=479, r=1 → 4 writes to 306558, 306559, 307198, 307199.
- r=0 at x=5, y=3 → exactly 1 write to 1925. oBusy high for 3 cycles.
- Reject and ignore:
  - x=700, y=10 → zero writes; oDone in the 2nd cycle after the start edge.
  - iStart pulsed during DRAW of a prior stamp → ignored; the write count of the first stamp is unchanged.
- Reset mid-draw: assert iRST_n low during write 4 of a 9-write stamp.
  - oWr_en, oBusy and oDone go 0 immediately.
  - No further writes after release.
  - A subsequent start behaves normally.
